// File: rtl/e203_tohost_icb_slave_if.sv
// ICB bus bundle for the tohost slave: one command channel and one response
// channel. The master modport drives commands and accepts responses. The
// slave modport accepts commands and drives responses.
interface e203_tohost_icb_slave_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/e203_tohost_icb_slave.sv
// Tohost test-completion slave on an ICB port.
// The slave exposes a 16-byte register window at BASE_ADDR:
//   +0x0 TOHOST   (R/W)  a write with bit0=1 ends the test
//   +0x4 FROMHOST (R/W)  scratch register
//   +0x8 STATUS   (RO)   {30'b0, test_pass, test_done}
//   +0xC CYCLE    (RO)   free-running cycle counter
// The first completing TOHOST write sets test_done, test_pass, test_code and
// done_cycle. These values then stay frozen until reset.
// Optional feature: define E203_TOHOST_CYCLE_CNT_EN to build the cycle
// counter. When it is undefined, CYCLE reads 0 and done_cycle is tied to 0.
module e203_tohost_icb_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  e203_tohost_icb_slave_if.slave icb,
  output logic                   test_done,
  output logic                   test_pass,
  output logic [30:0]            test_code,
  output logic [31:0]            wr_count,
  output logic [31:0]            done_cycle
);

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REG_TOHOST   = 2'd0,
    REG_FROMHOST = 2'd1,
    REG_STATUS   = 2'd2,
    REG_CYCLE    = 2'd3
  } reg_sel_t;

  // Merges write data into a register, one byte per mask bit.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wmask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic        cmd_accept;
  logic        in_window;
  reg_sel_t    reg_sel;
  logic [31:0] rd_data;
  logic [31:0] cycle_val;
  logic        wr_en;
  logic        tohost_we;
  logic        fromhost_we;
  logic [31:0] tohost_q;
  logic [31:0] fromhost_q;
  logic [31:0] tohost_merged;
  logic        complete;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  // The sub-word byte offset does not affect the register selection.
  logic        addr_lsb_unused;
  assign addr_lsb_unused = ^icb.icb_cmd_addr[1:0];

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  // A new command can be taken in two cases: no response is pending, or the
  // pending response retires in this cycle. The rst gate holds ready low
  // while the block is in reset.
  assign icb.icb_cmd_ready = ~rst & ((state_q == IDLE) | icb.icb_rsp_ready);
  assign cmd_accept        = icb.icb_cmd_valid & icb.icb_cmd_ready;
  assign icb.icb_rsp_valid = (state_q == RSP);
  assign icb.icb_rsp_rdata = rsp_rdata_q;
  assign icb.icb_rsp_err   = rsp_err_q;

  // State register: at most one response outstanding.
  // NOTE: reset is asynchronous. A pending response disappears as soon as
  // rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // flop samples values from before the edge.
      state_q <= state_d;
    end
  end

  // Next-state logic: the state goes back to IDLE only when the response
  // retires and no new command replaces it.
  always_comb begin
    // NOTE: the default assignment comes first, so no path leaves state_d
    // unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_accept) state_d = RSP;
      RSP: begin
        if (cmd_accept)             state_d = RSP;
        else if (icb.icb_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Address decode and read mux
  // ------------------------------------------------------------------
  assign in_window = (icb.icb_cmd_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = reg_sel_t'(icb.icb_cmd_addr[3:2]);

  // Read mux: returns the register values from before any write in this
  // same cycle.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_TOHOST:   rd_data = tohost_q;
      REG_FROMHOST: rd_data = fromhost_q;
      REG_STATUS:   rd_data = {30'b0, test_pass, test_done};
      REG_CYCLE:    rd_data = cycle_val;
      default:      rd_data = '0;
    endcase
  end

  // Response payload register: it loads only when a command is accepted, so
  // it holds steady while the master stalls the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (cmd_accept) begin
      rsp_err_q   <= ~in_window;
      rsp_rdata_q <= (icb.icb_cmd_read && in_window) ? rd_data : 32'h0;
    end
  end

  // ------------------------------------------------------------------
  // Writable registers
  // ------------------------------------------------------------------
  assign wr_en         = cmd_accept & ~icb.icb_cmd_read & in_window;
  assign tohost_we     = wr_en & (reg_sel == REG_TOHOST);
  assign fromhost_we   = wr_en & (reg_sel == REG_FROMHOST);
  assign tohost_merged = merge_bytes(tohost_q, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
  assign complete      = tohost_we & ~test_done & tohost_merged[0];

  // TOHOST, FROMHOST and the TOHOST write counter. The counter also counts
  // writes with an empty mask and writes that arrive after completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_q   <= '0;
      fromhost_q <= '0;
      wr_count   <= '0;
    end else begin
      if (tohost_we) begin
        tohost_q <= tohost_merged;
        wr_count <= wr_count + 32'd1;
      end
      if (fromhost_we) begin
        fromhost_q <= merge_bytes(fromhost_q, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
      end
    end
  end

  // Completion capture: the first TOHOST value with bit0=1 wins. Later
  // completing writes are ignored until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_done <= 1'b0;
      test_pass <= 1'b0;
      test_code <= '0;
    end else if (complete) begin
      test_done <= 1'b1;
      test_pass <= (tohost_merged == 32'h1);
      test_code <= tohost_merged[31:1];
    end
  end

  // ------------------------------------------------------------------
  // Optional cycle counter
  // ------------------------------------------------------------------
`ifdef E203_TOHOST_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;

  // Free-running cycle counter that wraps at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycle_val = cycle_cnt;

  // done_cycle holds the counter value from the cycle in which the
  // completing write is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           done_cycle <= '0;
    else if (complete) done_cycle <= cycle_cnt;
  end
`else
  assign cycle_val  = '0;
  assign done_cycle = '0;
`endif

endmodule

// File: tb/tb_e203_tohost_icb_slave.sv
// Self-checking bench for e203_tohost_icb_slave.
// The driver queues the expected response for each accepted command. A
// monitor on the falling edge pops and compares every response handshake.
// The directed checks on the status outputs use the same counters.
module tb_e203_tohost_icb_slave;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_done;
  logic        test_pass;
  logic [30:0] test_code;
  logic [31:0] wr_count;
  logic [31:0] done_cycle;
  logic [31:0] tb_cyc;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  e203_tohost_icb_slave_if bus ();

  e203_tohost_icb_slave #(.BASE_ADDR(BASE)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .icb        (bus),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .test_code  (test_code),
    .wr_count   (wr_count),
    .done_cycle (done_cycle)
  );

  // Reference cycle count: it starts at 0 when reset is released and adds
  // one on every clock edge after that.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 0;
    else     tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares each response as its handshake happens.
  always @(negedge clk) begin
    if (!rst && bus.icb_rsp_valid && bus.icb_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata %h err %b with nothing expected (t=%0t)",
                 bus.icb_rsp_rdata, bus.icb_rsp_err, $time);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", bus.icb_rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, bus.icb_rsp_err}, {31'b0, e.err});
      end
    end
  end

  // Waits n cycles, then returns 1 time unit after the last rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one command and records its expected response. The task returns
  // 1 time unit after the acceptance edge. no_wait requires the command to
  // be accepted in the first cycle it is offered.
  task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic [31:0] exp_rdata,
                       input logic exp_err, input bit no_wait);
    int   waits;
    rsp_t e;
    waits = 0;
    bus.icb_cmd_valid = 1'b1;
    bus.icb_cmd_addr  = addr;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_wdata = wdata;
    bus.icb_cmd_wmask = wmask;
    @(negedge clk);
    while (!bus.icb_cmd_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.icb_cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: addr %h not accepted in %0d cycles", addr, waits);
      bus.icb_cmd_valid = 1'b0;
      return;
    end
    if (no_wait) check("no_bubble_wait", waits, 0);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.icb_cmd_valid = 1'b0;
    check("rsp_latency", {31'b0, bus.icb_rsp_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"},  {31'b0, bus.icb_cmd_ready}, 32'd0);
    check({tag, "_rsp_valid"},  {31'b0, bus.icb_rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"},  bus.icb_rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},    {31'b0, bus.icb_rsp_err}, 32'd0);
    check({tag, "_test_done"},  {31'b0, test_done}, 32'd0);
    check({tag, "_test_pass"},  {31'b0, test_pass}, 32'd0);
    check({tag, "_test_code"},  {1'b0, test_code}, 32'd0);
    check({tag, "_wr_count"},   wr_count, 32'd0);
    check({tag, "_done_cycle"}, done_cycle, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_rsp_ready = 1'b1;
    exp_q.delete();
    idle(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);
  endtask

  task automatic check_status(input string tag, input logic done, input logic pass,
                              input logic [30:0] code, input logic [31:0] cnt);
    check({tag, "_test_done"}, {31'b0, test_done}, {31'b0, done});
    check({tag, "_test_pass"}, {31'b0, test_pass}, {31'b0, pass});
    check({tag, "_test_code"}, {1'b0, test_code}, {1'b0, code});
    check({tag, "_wr_count"},  wr_count, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_dc;
    logic [31:0] exp_cyc;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_addr  = '0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_wdata = '0;
    bus.icb_cmd_wmask = '0;
    bus.icb_rsp_ready = 1'b1;
    #1;
    do_reset();

    // Passing completion.
    issue(BASE + 32'h0, 1'b0, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0);
    check_status("pass_write", 1'b1, 1'b1, 31'd0, 32'd1);
    issue(BASE + 32'h8, 1'b1, 32'h0, 4'h0, 32'h3, 1'b0, 1'b0);
    issue(BASE + 32'h0, 1'b1, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0);
    idle(1);

    // Failing completion, first result wins, STATUS writes and empty masks.
    do_reset();
    issue(BASE + 32'h0, 1'b0, 32'h7, 4'hF, 32'h0, 1'b0, 1'b0);
    check_status("fail_write", 1'b1, 1'b0, 31'd3, 32'd1);
    issue(BASE + 32'h0, 1'b0, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0);
    check_status("after_done_write", 1'b1, 1'b0, 31'd3, 32'd2);
    issue(BASE + 32'h8, 1'b1, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0);
    issue(BASE + 32'h0, 1'b1, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0);
    issue(BASE + 32'h8, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 1'b0);
    issue(BASE + 32'h8, 1'b1, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0);
    issue(BASE + 32'h0, 1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1'b0);
    check_status("empty_mask_write", 1'b1, 1'b0, 31'd3, 32'd3);
    issue(BASE + 32'h0, 1'b1, 32'h0, 4'h0, 32'h1, 1'b0, 1'b0);
    idle(1);

    // Non-completing store, out-of-window accesses and byte merging.
    do_reset();
    issue(BASE + 32'h0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0);
    check_status("bit0_clear_write", 1'b0, 1'b0, 31'd0, 32'd1);
    issue(BASE + 32'h0, 1'b1, 32'h0, 4'h0, 32'h10, 1'b0, 1'b0);
    issue(BASE + 32'h10, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    issue(BASE + 32'h10, 1'b0, 32'h1, 4'hF, 32'h0, 1'b1, 1'b0);
    issue(BASE - 32'h4, 1'b1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    check_status("out_of_window", 1'b0, 1'b0, 31'd0, 32'd1);
    issue(BASE + 32'h4, 1'b0, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0);
    issue(BASE + 32'h4, 1'b0, 32'h0000_00FF, 4'h1, 32'h0, 1'b0, 1'b0);
    issue(BASE + 32'h4, 1'b1, 32'h0, 4'h0, 32'h1234_56FF, 1'b0, 1'b0);
    issue(BASE + 32'h7, 1'b1, 32'h0, 4'h0, 32'h1234_56FF, 1'b0, 1'b0);
    issue(BASE + 32'h4, 1'b0, 32'hAABB_CCDD, 4'hA, 32'h0, 1'b0, 1'b0);
    issue(BASE + 32'h4, 1'b1, 32'h0, 4'h0, 32'hAA34_CCFF, 1'b0, 1'b0);
    idle(1);

    // Stalled response, then back-to-back reads with no bubble.
    bus.icb_rsp_ready = 1'b0;
    issue(BASE + 32'h4, 1'b0, 32'hA5A5_0000, 4'hF, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", {31'b0, bus.icb_cmd_ready}, 32'd0);
      check("stall_rsp_valid", {31'b0, bus.icb_rsp_valid}, 32'd1);
      check("stall_rsp_rdata", bus.icb_rsp_rdata, 32'h0);
      check("stall_rsp_err",   {31'b0, bus.icb_rsp_err}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.icb_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(BASE + 32'h4, 1'b1, 32'h0, 4'h0, 32'hA5A5_0000, 1'b0, 1'b1);
    end
    idle(1);
    check("rsp_idle_after_burst", {31'b0, bus.icb_rsp_valid}, 32'd0);

    // Reset while a response is pending.
    bus.icb_rsp_ready = 1'b0;
    issue(BASE + 32'h0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_pending");
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    bus.icb_rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", {31'b0, bus.icb_rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Completion timestamp: the completing write is accepted at cycle 100.
    while (tb_cyc != 100) begin
      @(posedge clk);
      #1;
    end
`ifdef E203_TOHOST_CYCLE_CNT_EN
    exp_dc = 32'd100;
`else
    exp_dc = 32'd0;
`endif
    issue(BASE + 32'h0, 1'b0, 32'h1, 4'hF, 32'h0, 1'b0, 1'b0);
    check_status("timed_pass", 1'b1, 1'b1, 31'd0, 32'd1);
    check("done_cycle", done_cycle, exp_dc);
`ifdef E203_TOHOST_CYCLE_CNT_EN
    exp_cyc = tb_cyc;
`else
    exp_cyc = 32'd0;
`endif
    issue(BASE + 32'hC, 1'b1, 32'h0, 4'h0, exp_cyc, 1'b0, 1'b0);
    issue(BASE + 32'h0, 1'b0, 32'h3, 4'hF, 32'h0, 1'b0, 1'b0);
    check_status("frozen_after_pass", 1'b1, 1'b1, 31'd0, 32'd2);
    check("done_cycle_frozen", done_cycle, exp_dc);
    idle(2);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e203_tohost_icb_slave.md
E203_TOHOST_ICB_SLAVE -- requirements
Module: e203_tohost_icb_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000: base of a 16-byte register window, 16-byte aligned.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- icb_cmd_valid  in  1  ICB command valid.
- icb_cmd_ready  out  1  ICB command ready.
- icb_cmd_addr  in  32  byte address.
- icb_cmd_read  in  1  1=read, 0=write.
- icb_cmd_wdata  in  32  write data.
- icb_cmd_wmask  in  4  byte enables, bit n = byte n.
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_rdata  out  32  read data.
- icb_rsp_err  out  1  error response.
- test_done  out  1  sticky completion flag.
- test_pass  out  1  valid only when test_done=1.
- test_code  out  31  tohost[31:1] captured at completion.
- wr_count  out  32  count of accepted TOHOST writes.
- done_cycle  out  32  cycle count captured at completion.

Function
REQ-003 Register map, offset = addr[3:2]: 0 TOHOST R/W; 1 FROMHOST R/W; 2 STATUS RO {30'b0, test_pass, test_done}; 3 CYCLE RO.
REQ-004 Address outside [BASE_ADDR, BASE_ADDR+15]: response err=1, rdata=0, no state change; addr[1:0] ignored.
REQ-005 Writes to TOHOST/FROMHOST merge wdata per wmask; writes to STATUS/CYCLE are accepted, err=0, no effect.
REQ-006 Handshake: command accepted when icb_cmd_valid & icb_cmd_ready; icb_cmd_ready = ~icb_rsp_valid | icb_rsp_ready; at most one response outstanding.
REQ-007 Two states, IDLE and RSP. IDLE->RSP on acceptance. RSP->IDLE on rsp handshake with no new acceptance. RSP->RSP when rsp handshake and new acceptance coincide; the new response is presented the next cycle with no bubble.
REQ-008 Latency: response valid exactly 1 cycle after acceptance; rdata and err registered, held stable while icb_rsp_valid & ~icb_rsp_ready.
REQ-009 Read data reflects register state before any side effect of the same command; write responses return rdata=0.
REQ-010 Every accepted in-window TOHOST write SHALL increment wr_count (wraps 32'hFFFF_FFFF->0), including writes after test_done.
REQ-011 Merged TOHOST value with bit0=1 while test_done=0: next cycle test_done=1, test_pass=(value==32'h1), test_code=value[31:1]. If bit0=0: value stored only, no completion.
REQ-012 After test_done=1: test_done, test_pass, test_code and done_cycle frozen until reset; first result wins.
REQ-013 Mask wmask=4'h0 write: accepted, responded, register unchanged, wr_count still incremented for TOHOST.

Reset
REQ-014 While rst=1: icb_cmd_ready=0, icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, test_done=0, test_pass=0, test_code=0, wr_count=0, done_cycle=0; TOHOST, FROMHOST and cycle counter=0.
REQ-015 Reset asserted with a response pending SHALL discard it; no response is issued after deassertion.

Configuration
REQ-016 Macro E203_TOHOST_CYCLE_CNT_EN defined: 32-bit free-running counter increments every cycle from 0 after reset (wraps), readable at CYCLE; done_cycle captures it in the cycle the completing write is accepted.
REQ-017 Macro undefined: no counter; CYCLE reads 0; done_cycle tied to 0; all other behaviour identical.

Verification
REQ-018 Write TOHOST=32'h1, wmask=F -> one-cycle rsp err=0; next cycle test_done=1, test_pass=1, test_code=0, wr_count=1.
REQ-019 Write TOHOST=32'h7 then 32'h1 -> test_done=1, test_pass=0, test_code=3, wr_count=2; STATUS read returns 32'h1.
REQ-020 Hold icb_rsp_ready=0 for 5 cycles after FROMHOST write 32'hA5A5_0000 -> cmd_ready=0, rsp stable; back-to-back FROMHOST read with rsp_ready=1 -> rdata 32'hA5A5_0000, one response per cycle.
REQ-021 Read BASE_ADDR+32'h10 -> err=1, rdata=0, wr_count unchanged; byte write wdata=32'h0000_00FF, wmask=4'h1 to FROMHOST=32'h1234_5678 -> reads 32'h1234_56FF.
REQ-022 Assert rst with response pending -> rsp_valid drops same cycle, all outputs 0; with E203_TOHOST_CYCLE_CNT_EN, completing write accepted at cycle 100 -> done_cycle=100; without macro -> done_cycle=0, CYCLE reads 0.
